// File: rtl/shift_chain_pkg.sv
// Purpose : shared types and helpers for the shift-chain sequencer.
// Latency : n/a (definitions only).
// Backpressure: n/a.
// State encodings: IDLE=0, SHIFT=1, DRAIN=2, DONE=3 (2-bit).
package shift_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit-index width for a w-bit word; never below 1 so selects stay legal.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_chain_rx.sv
// Purpose : WIDTH-bit capture register, one indexed bit written per cycle.
// Latency : written bit visible on rx_next in the same cycle, in rx_q after the edge.
// Backpressure: none; a write happens whenever wr_en is high.
// Ports   : clk/rst (sync, active-high); wr_en/wr_idx/wr_bit write one bit;
//           rx_next is the register contents including this cycle's write.
module shift_chain_rx #(
    parameter int WIDTH = 8,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic             wr_bit,
    output logic [WIDTH-1:0] rx_next
);

    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] rx_d;

    always_comb begin
        rx_d = rx_q;
        if (wr_en) begin
            rx_d[wr_idx] = wr_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q <= '0;
        end else begin
            rx_q <= rx_d;
        end
    end

    // Exposing the post-write value lets the top complete on the same edge
    // that samples the final bit.
    assign rx_next = rx_d;

endmodule

// File: rtl/shift_chain_ctrl.sv
// Purpose : serialise a word LSB-first into a DEPTH-flop chain, reassemble its output, flag intact return.
// Latency : accepting edge to done pulse = WIDTH+DEPTH+1 edges.
// Backpressure: start is ignored while busy (SHIFT/DRAIN/DONE); din is latched only on acceptance.
// Ports   : clk, rst (sync, active-high); start/din request; ser_d -> chain input,
//           ser_q <- chain output; busy, done pulse, dout/match held until next completion.
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_q,
    output logic             ser_d,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             match
);

    localparam int CW = $clog2(WIDTH + DEPTH + 1);
    localparam int IW = idx_width(WIDTH);

    localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_CYC   = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             match_q, match_d;

    logic             cap_en;
    logic             last_cyc;
    logic [CW-1:0]    cap_off;
    logic [IW-1:0]    cap_idx;
    logic [IW-1:0]    tx_idx;
    logic [WIDTH-1:0] rx_next;

    // State register (all flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            tx_q    <= '0;
            dout_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            tx_q    <= tx_d;
            dout_q  <= dout_d;
            match_q <= match_d;
        end
    end

    // Next-state logic; cyc runs continuously across SHIFT and DRAIN.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        tx_d    = tx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    tx_d    = din;
                    cyc_d   = '0;
                end
            end
            ST_SHIFT: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == LAST_SHIFT) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == LAST_CYC) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture window: chain output for bit i appears DEPTH cycles after bit i
    // was driven, so capture starts at cyc==DEPTH and may overlap SHIFT.
    assign tx_idx   = cyc_q[IW-1:0];
    assign cap_off  = cyc_q - DEPTH_C;
    assign cap_idx  = cap_off[IW-1:0];
    assign cap_en   = ((state_q == ST_SHIFT) || (state_q == ST_DRAIN)) && (cyc_q >= DEPTH_C);
    assign last_cyc = (state_q == ST_DRAIN) && (cyc_q == LAST_CYC);

    shift_chain_rx #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap_en),
        .wr_idx  (cap_idx),
        .wr_bit  (ser_q),
        .rx_next (rx_next)
    );

    // Result is taken from rx_next so the bit sampled on the final edge is included.
    always_comb begin
        dout_d  = dout_q;
        match_d = match_q;
        if (last_cyc) begin
            dout_d  = rx_next;
            match_d = (rx_next == tx_q);
        end
    end

    // Output logic.
    always_comb begin
        ser_d = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            ST_IDLE:  begin end
            ST_SHIFT: begin busy = 1'b1; ser_d = tx_q[tx_idx]; end
            ST_DRAIN: begin busy = 1'b1; end
            ST_DONE:  begin busy = 1'b1; done = 1'b1; end
            default:  begin end
        endcase
    end

    assign dout  = dout_q;
    assign match = match_q;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
module tb_shift_chain_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=8, DEPTH=2
    logic       start0 = 1'b0;
    logic [7:0] din0   = 8'h00;
    logic       ser_q0, ser_d0, busy0, done0, match0;
    logic [7:0] dout0;
    logic [1:0] chain0;
    logic       flip = 1'b0;

    // Instance 1: WIDTH=8, DEPTH=1
    logic       start1 = 1'b0;
    logic [7:0] din1   = 8'h00;
    logic       ser_q1, ser_d1, busy1, done1, match1;
    logic [7:0] dout1;
    logic       chain1;

    int errors = 0;
    int checks = 0;

    // Chain models: DEPTH clocked D flops from ser_d to ser_q.
    always @(posedge clk) begin
        if (rst) begin
            chain0 <= 2'b00;
            chain1 <= 1'b0;
        end else begin
            chain0 <= {chain0[0], ser_d0};
            chain1 <= ser_d1;
        end
    end
    assign ser_q0 = chain0[1] ^ flip;
    assign ser_q1 = chain1;

    shift_chain_ctrl #(.WIDTH(8), .DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .din(din0), .ser_q(ser_q0),
        .ser_d(ser_d0), .busy(busy0), .done(done0), .dout(dout0), .match(match0)
    );

    shift_chain_ctrl #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .din(din1), .ser_q(ser_q1),
        .ser_d(ser_d1), .busy(busy1), .done(done1), .dout(dout1), .match(match1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept0(input logic [7:0] d);
        start0 = 1'b1;
        din0   = d;
        step();
        start0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; din0 = 8'hFF; start1 = 1'b1; din1 = 8'hFF;
        step(); step();
        checks += 6;
        if (busy0 !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", busy0); end
        if (done0 !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b want=0", done0); end
        if (ser_d0 !== 1'b0)  begin errors++; $display("FAIL reset_ser_d got=%b want=0", ser_d0); end
        if (dout0 !== 8'h00)  begin errors++; $display("FAIL reset_dout got=%h want=00", dout0); end
        if (match0 !== 1'b0)  begin errors++; $display("FAIL reset_match got=%b want=0", match0); end
        if (busy1 !== 1'b0)   begin errors++; $display("FAIL reset_busy_d1 got=%b want=0", busy1); end
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        step();
    endtask

    task automatic test_loopback();
        logic [7:0] exp_bits;
        exp_bits = 8'hA5;
        accept0(8'hA5);
        for (int c = 0; c <= 10; c++) begin
            checks += 2;
            if (busy0 !== 1'b1) begin errors++; $display("FAIL loop_busy c=%0d got=%b want=1", c, busy0); end
            if (done0 !== (c == 10)) begin errors++; $display("FAIL loop_done c=%0d got=%b want=%b", c, done0, (c == 10)); end
            if (c < 8) begin
                checks++;
                if (ser_d0 !== exp_bits[c]) begin errors++; $display("FAIL loop_ser_d c=%0d got=%b want=%b", c, ser_d0, exp_bits[c]); end
            end else begin
                checks++;
                if (ser_d0 !== 1'b0) begin errors++; $display("FAIL loop_ser_d_idle c=%0d got=%b want=0", c, ser_d0); end
            end
            if (c == 10) begin
                checks += 2;
                if (dout0 !== 8'hA5) begin errors++; $display("FAIL loop_dout got=%h want=a5", dout0); end
                if (match0 !== 1'b1) begin errors++; $display("FAIL loop_match got=%b want=1", match0); end
            end
            step();
        end
        checks += 2;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL loop_idle_busy got=%b want=0", busy0); end
        if (done0 !== 1'b0) begin errors++; $display("FAIL loop_idle_done got=%b want=0", done0); end
    endtask

    task automatic test_fault();
        accept0(8'hA5);
        repeat (5) step();          // now in cycle 5
        flip = 1'b1;
        step();                     // cycle 6
        flip = 1'b0;
        repeat (4) step();          // cycle 10
        checks += 3;
        if (done0 !== 1'b1)  begin errors++; $display("FAIL fault_done got=%b want=1", done0); end
        if (dout0 !== 8'hAD) begin errors++; $display("FAIL fault_dout got=%h want=ad", dout0); end
        if (match0 !== 1'b0) begin errors++; $display("FAIL fault_match got=%b want=0", match0); end
        step();
    endtask

    task automatic test_busy_start();
        accept0(8'hA5);
        repeat (3) step();          // cycle 3
        start0 = 1'b1; din0 = 8'h3C;
        step();                     // cycle 4
        start0 = 1'b0;
        repeat (6) step();          // cycle 10
        start0 = 1'b1;
        checks += 3;
        if (done0 !== 1'b1)  begin errors++; $display("FAIL busy_done got=%b want=1", done0); end
        if (dout0 !== 8'hA5) begin errors++; $display("FAIL busy_dout got=%h want=a5", dout0); end
        if (match0 !== 1'b1) begin errors++; $display("FAIL busy_match got=%b want=1", match0); end
        step();                     // cycle 11, IDLE
        start0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_no_rerun k=%0d got=%b want=0", k, busy0); end
            step();
        end
    endtask

    task automatic test_midop_reset();
        accept0(8'hA5);
        repeat (4) step();          // cycle 4
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks += 5;
        if (busy0 !== 1'b0)  begin errors++; $display("FAIL mid_busy got=%b want=0", busy0); end
        if (done0 !== 1'b0)  begin errors++; $display("FAIL mid_done got=%b want=0", done0); end
        if (ser_d0 !== 1'b0) begin errors++; $display("FAIL mid_ser_d got=%b want=0", ser_d0); end
        if (dout0 !== 8'h00) begin errors++; $display("FAIL mid_dout got=%h want=00", dout0); end
        if (match0 !== 1'b0) begin errors++; $display("FAIL mid_match got=%b want=0", match0); end
        accept0(8'hFF);
        repeat (10) step();         // cycle 10
        checks += 3;
        if (done0 !== 1'b1)  begin errors++; $display("FAIL mid_rerun_done got=%b want=1", done0); end
        if (dout0 !== 8'hFF) begin errors++; $display("FAIL mid_rerun_dout got=%h want=ff", dout0); end
        if (match0 !== 1'b1) begin errors++; $display("FAIL mid_rerun_match got=%b want=1", match0); end
        step();
    endtask

    task automatic test_back_to_back();
        start0 = 1'b1; din0 = 8'h3C;
        step();                     // cycle 0, start held high
        repeat (10) step();         // cycle 10
        checks++;
        if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b want=1", done0); end
        step();                     // cycle 11, IDLE
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b want=0", busy0); end
        step();                     // retriggered: cycle 0 of run 2
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_retrigger got=%b want=1", busy0); end
        repeat (10) step();
        checks += 3;
        if (done0 !== 1'b1)  begin errors++; $display("FAIL b2b_done2 got=%b want=1", done0); end
        if (dout0 !== 8'h3C) begin errors++; $display("FAIL b2b_dout got=%h want=3c", dout0); end
        if (match0 !== 1'b1) begin errors++; $display("FAIL b2b_match got=%b want=1", match0); end
        step();
    endtask

    task automatic test_depth1();
        logic [7:0] exp_bits;
        exp_bits = 8'h01;
        start1 = 1'b1; din1 = 8'h01;
        step();
        start1 = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            checks++;
            if (done1 !== (c == 9)) begin errors++; $display("FAIL d1_done c=%0d got=%b want=%b", c, done1, (c == 9)); end
            if (c < 8) begin
                checks++;
                if (ser_d1 !== exp_bits[c]) begin errors++; $display("FAIL d1_ser_d c=%0d got=%b want=%b", c, ser_d1, exp_bits[c]); end
            end
            if (c == 9) begin
                checks += 2;
                if (dout1 !== 8'h01) begin errors++; $display("FAIL d1_dout got=%h want=01", dout1); end
                if (match1 !== 1'b1) begin errors++; $display("FAIL d1_match got=%b want=1", match1); end
            end
            step();
        end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL d1_idle got=%b want=0", busy1); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        test_reset();
        test_loopback();
        test_fault();
        test_busy_start();
        test_midop_reset();
        test_back_to_back();
        test_depth1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
